// File: rtl/z16_bus_pkg.sv
// Shared Z16 bus definitions: response owner codes,
// word width and MMIO byte addresses.
package z16_bus_pkg;

   localparam int WORD_W = 16;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_F    = 2'd1;
   localparam logic [1:0] OWN_DLD  = 2'd2;
   localparam logic [1:0] OWN_DERR = 2'd3;

   localparam logic [15:0] LED_ADDR    = 16'd122;
   localparam logic [15:0] BUTTON_ADDR = 16'd124;

endpackage

// File: rtl/z16_starve_counter.sv
// Counts consecutive fetch losses, saturating at MAX_STARVE;
// at_max forces the next fetch grant.
module z16_starve_counter #(
   parameter int MAX_STARVE = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic req,
   input  logic gnt,
   output logic at_max
);

   localparam logic [3:0] MAX = 4'(MAX_STARVE);

   logic [3:0] cnt;

   // count denied request cycles, clear on grant or idle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (req && !gnt) begin
         if (cnt != MAX) cnt <= cnt + 4'd1;
      end else begin
         cnt <= '0;
      end
   end

   assign at_max = (cnt == MAX);

endmodule

// File: rtl/z16_mem_arbiter.sv
// Arbitrates fetch and data ports onto one synchronous RAM;
// data wins unless fetch has starved MAX_STARVE cycles.
module z16_mem_arbiter
   import z16_bus_pkg::*;
#(
   parameter int MEM_AW     = 8,
   parameter int MAX_STARVE = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_f_req,
   input  logic [15:0]       i_f_addr,
   output logic              o_f_gnt,
   output logic              o_f_rvalid,
   output logic [WORD_W-1:0] o_f_rdata,
   input  logic              i_d_req,
   input  logic              i_d_we,
   input  logic [15:0]       i_d_addr,
   input  logic [WORD_W-1:0] i_d_wdata,
   output logic              o_d_gnt,
   output logic              o_d_rvalid,
   output logic [WORD_W-1:0] o_d_rdata,
   output logic              o_d_err,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [MEM_AW-1:0] o_mem_addr,
   output logic [WORD_W-1:0] o_mem_wdata,
   input  logic [WORD_W-1:0] i_mem_rdata
);

   logic       at_max;
   logic       f_win;
   logic       d_win;
   logic       d_bad;
   logic       d_ok;
   logic [1:0] own_q;
   logic [1:0] own_d;
   logic       ld_q;
   logic       ld_d;
   logic       f_rv;
   logic       d_ld;
   logic       d_er;

   // fetch ignores low/high address bits by design
   logic unused_bits;
   assign unused_bits = &{1'b0, i_f_addr[15:MEM_AW+1], i_f_addr[0]};

   z16_starve_counter #(
      .MAX_STARVE(MAX_STARVE)
   ) u_starve (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .req    (i_f_req),
      .gnt    (f_win),
      .at_max (at_max)
   );

   // grants are held low while reset is asserted
   assign f_win = i_rst_n & i_f_req & (~i_d_req | at_max);
   assign d_win = i_rst_n & i_d_req & ~f_win;

   assign d_bad = i_d_addr[0] | (|i_d_addr[15:MEM_AW+1]);
   assign d_ok  = d_win & ~d_bad;

   assign o_f_gnt     = f_win;
   assign o_d_gnt     = d_win;
   assign o_mem_en    = f_win | d_ok;
   assign o_mem_we    = d_ok & i_d_we;
   assign o_mem_addr  = f_win ? i_f_addr[MEM_AW:1]
                              : i_d_addr[MEM_AW:1];
   assign o_mem_wdata = (d_ok & i_d_we) ? i_d_wdata : '0;

   // decide who owns next cycle's response
   always_comb begin
      own_d = OWN_NONE;
      ld_d  = 1'b0;
      unique case (1'b1)
         f_win: own_d = OWN_F;
         d_win & d_bad: begin
            own_d = OWN_DERR;
            ld_d  = ~i_d_we;
         end
         d_ok & ~i_d_we: own_d = OWN_DLD;
         default: ;
      endcase
   end

   // response owner register, dropped on reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         own_q <= OWN_NONE;
         ld_q  <= 1'b0;
      end else begin
         own_q <= own_d;
         ld_q  <= ld_d;
      end
   end

   assign f_rv = (own_q == OWN_F);
   assign d_ld = (own_q == OWN_DLD);
   assign d_er = (own_q == OWN_DERR);

   assign o_f_rvalid = f_rv;
   assign o_f_rdata  = f_rv ? i_mem_rdata : '0;
   assign o_d_rvalid = d_ld | (d_er & ld_q);
   assign o_d_rdata  = d_ld ? i_mem_rdata : '0;
   assign o_d_err    = d_er;

endmodule
